fetch_prefetch_buffer: RTL and testbench

//  Parametrised prefetch unit between the instruction bus and decode.

---
 rtl/fetch_prefetch_buffer.sv | 160 ++++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: keeps word requests in flight on the instruction bus,
// buffers returned words and realigns mixed 16/32-bit instructions for decode.
module fetch_prefetch_buffer #(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int unsigned DEPTH           = 3,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_rvalid_i,
  input  logic        instr_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_err_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t MAX_C   = cnt_t'(MAX_OUTSTANDING);

  logic [31:0]      fifo_data_q [DEPTH];
  logic [31:0]      fifo_data_d [DEPTH];
  logic [DEPTH-1:0] fifo_err_q, fifo_err_d;
  cnt_t             fifo_count_q, fifo_count_d;
  cnt_t             outstanding_q, outstanding_d;
  cnt_t             discard_q, discard_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic             run_q;

  logic [CNT_W:0] in_flight;
  logic           rvalid_eff, push, pop, accept;
  logic [15:0]    half;
  logic           dec_valid, dec_comp, dec_err, dec_pop;
  logic [31:0]    dec_instr;
  cnt_t           wr_idx;

  // run_q keeps the bus request low while reset is held.
  assign in_flight    = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
  assign instr_req_o  = run_q && (outstanding_q < MAX_C) &&
                        (in_flight < {1'b0, DEPTH_C}) && !redirect_i;
  assign instr_addr_o = fetch_addr_q;

  // Responses with nothing outstanding (e.g. after reset) are stale and ignored.
  assign rvalid_eff = instr_rvalid_i && (outstanding_q != '0);
  assign push       = rvalid_eff && (discard_q == '0);
  assign accept     = dec_valid && out_ready_i && !redirect_i;
  assign pop        = accept && dec_pop;

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    half      = out_pc_q[1] ? fifo_data_q[0][31:16] : fifo_data_q[0][15:0];
    dec_valid = 1'b0;
    dec_comp  = 1'b0;
    dec_err   = 1'b0;
    dec_pop   = 1'b0;
    dec_instr = fifo_data_q[0];
    if (fifo_err_q[0]) begin
      dec_valid = (fifo_count_q != '0);
      dec_err   = 1'b1;
      dec_pop   = 1'b1;
    end else if (half[1:0] != 2'b11) begin
      dec_valid = (fifo_count_q != '0);
      dec_comp  = 1'b1;
      dec_instr = {16'h0, half};
      dec_pop   = out_pc_q[1];
    end else if (!out_pc_q[1]) begin
      dec_valid = (fifo_count_q != '0);
      dec_pop   = 1'b1;
    end else begin
      // Unaligned 32-bit instruction straddles the head and the next entry.
      dec_valid = (fifo_count_q >= cnt_t'(2));
      dec_instr = {fifo_data_q[1][15:0], half};
      dec_err   = fifo_err_q[1];
      dec_pop   = 1'b1;
    end
  end

  always_comb begin
    fifo_data_d   = fifo_data_q;
    fifo_err_d    = fifo_err_q;
    fifo_count_d  = fifo_count_q;
    outstanding_d = outstanding_q - cnt_t'(rvalid_eff);
    discard_d     = discard_q;
    fetch_addr_d  = fetch_addr_q;
    out_pc_d      = out_pc_q;
    wr_idx        = fifo_count_q - cnt_t'(pop);
    if (redirect_i) begin
      fifo_count_d = '0;
      discard_d    = outstanding_q - cnt_t'(rvalid_eff);
      fetch_addr_d = redirect_pc_i & ~32'h3;
      out_pc_d     = redirect_pc_i;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          fifo_data_d[i] = fifo_data_q[i+1];
          fifo_err_d[i]  = fifo_err_q[i+1];
        end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && wr_idx == cnt_t'(i)) begin
          fifo_data_d[i] = instr_rdata_i;
          fifo_err_d[i]  = instr_err_i;
        end
      end
      fifo_count_d  = wr_idx + cnt_t'(push);
      outstanding_d = outstanding_q + cnt_t'(instr_req_o && instr_gnt_i) - cnt_t'(rvalid_eff);
      discard_d     = discard_q - cnt_t'(rvalid_eff && (discard_q != '0));
      if (instr_req_o && instr_gnt_i) fetch_addr_d = fetch_addr_q + 32'd4;
      if (accept) out_pc_d = out_pc_q + (dec_comp ? 32'd2 : 32'd4);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fetch_addr_q  <= PC_RESET & ~32'h3;
      out_pc_q      <= PC_RESET;
      run_q         <= 1'b0;
    end else begin
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_addr_q  <= fetch_addr_d;
      out_pc_q      <= out_pc_d;
      run_q         <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count_q qualifies every entry before use.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_err_q  <= fifo_err_d;
  end

  assign out_valid_o      = dec_valid;
  assign out_instr_o      = dec_valid ? dec_instr : 32'h0;
  assign out_compressed_o = dec_valid && dec_comp;
  assign out_err_o        = dec_valid && dec_err;
  assign out_pc_o         = out_pc_q;
  assign busy_o           = (outstanding_q != '0) || (fifo_count_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !redirect_i && fifo_count_q == DEPTH_C));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Randomized bench for fetch_prefetch_buffer: a memory-backed bus model feeds the DUT and
// an instruction-stream model derived from PC and memory contents predicts every output.
module tb_fetch_prefetch_buffer;

  localparam int DEPTH   = 3;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o, out_ready_i, out_compressed_o, out_err_o, busy_o;
  logic [31:0] out_instr_o, out_pc_o;

  fetch_prefetch_buffer #(
    .PC_RESET(32'h0), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_pc_o(out_pc_o), .out_compressed_o(out_compressed_o), .out_err_o(out_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic        err;
    logic [2:0]  len;
  } exp_t;

  logic [31:0] mem  [256];
  logic        merr [256];
  logic [31:0] bus_addr_q [$];
  int          bus_cyc_q  [$];
  logic [31:0] m_pc, exp_fetch;
  int          cyc = 0, n_acc = 0, first_valid_cyc = -1;
  bit          prev_redir = 0, prev_hold = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next instruction at pc, straight from the memory image and the RVC length rule.
  function automatic exp_t model_at(input logic [31:0] pc);
    exp_t        e;
    logic [7:0]  i0, i1;
    logic [31:0] w0, w1;
    logic [15:0] h;
    i0 = pc[9:2];
    i1 = i0 + 8'd1;
    w0 = mem[i0];
    w1 = mem[i1];
    h  = pc[1] ? w0[31:16] : w0[15:0];
    e  = '{instr: 32'h0, comp: 1'b0, err: 1'b0, len: 3'd4};
    if (merr[i0]) e.err = 1'b1;
    else if (h[1:0] != 2'b11) begin
      e.comp  = 1'b1;
      e.instr = {16'h0, h};
      e.len   = 3'd2;
    end else if (!pc[1]) e.instr = w0;
    else begin
      e.instr = {w1[15:0], h};
      e.err   = merr[i1];
    end
    return e;
  endfunction

  task automatic cycle(input int p_gnt, input int p_rv, input int p_rdy,
                       input bit do_redir, input logic [31:0] rpc);
    exp_t        e;
    logic [31:0] a;
    @(negedge clk);
    instr_gnt_i   = ($urandom_range(99) < p_gnt);
    out_ready_i   = ($urandom_range(99) < p_rdy);
    redirect_i    = do_redir;
    redirect_pc_i = rpc;
    if (bus_addr_q.size() != 0 && bus_cyc_q[0] < cyc && $urandom_range(99) < p_rv) begin
      a              = bus_addr_q[0];
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem[a[9:2]];
      instr_err_i    = merr[a[9:2]];
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
      instr_err_i    = 1'($urandom_range(1));
    end
    #1;
    if (prev_redir) check("valid_after_redirect", out_valid_o, 0);
    if (prev_hold)  check("valid_held", out_valid_o, 1);
    if (do_redir)   check("req_during_redirect", instr_req_o, 0);
    if (out_valid_o) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      e = model_at(m_pc);
      check("out_pc", out_pc_o, m_pc);
      check("out_compressed", out_compressed_o, e.comp);
      check("out_err", out_err_o, e.err);
      if (!e.err) check("out_instr", out_instr_o, e.instr);
      if (out_ready_i && !do_redir) begin
        m_pc += 32'(e.len);
        n_acc++;
      end
    end
    prev_hold  = out_valid_o && !out_ready_i && !do_redir;
    prev_redir = do_redir;
    if (instr_req_o && instr_gnt_i) begin
      check("fetch_addr", instr_addr_o, exp_fetch);
      bus_addr_q.push_back(instr_addr_o);
      bus_cyc_q.push_back(cyc);
      exp_fetch += 32'd4;
      check("max_outstanding", bus_addr_q.size() <= MAX_OUT, 1);
    end
    if (instr_rvalid_i) begin
      void'(bus_addr_q.pop_front());
      void'(bus_cyc_q.pop_front());
    end
    if (do_redir) begin
      m_pc      = rpc;
      exp_fetch = rpc & ~32'h3;
    end
    cyc++;
  endtask

  task automatic wait_valid(input int p_gnt, input int p_rdy, input string tag);
    for (int k = 0; k < 30; k++) begin
      cycle(p_gnt, 100, p_rdy, 1'b0, 32'h0);
      if (out_valid_o) break;
    end
    check(tag, out_valid_o, 1);
  endtask

  // Redirect away, then let every response come home so the DUT is idle and empty.
  task automatic quiesce();
    cycle(0, 100, 0, 1'b1, 32'h300);
    for (int k = 0; k < 30; k++) begin
      if (bus_addr_q.size() == 0) break;
      cycle(0, 100, 0, 1'b0, 32'h0);
    end
    check("drain", bus_addr_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; redirect_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_req", instr_req_o, 0);
    check("midrst_pc", out_pc_o, 32'h0);
    check("midrst_addr", instr_addr_o, 32'h0);
    bus_addr_q.delete();
    bus_cyc_q.delete();
    m_pc = 32'h0; exp_fetch = 32'h0;
    prev_redir = 0; prev_hold = 0; first_valid_cyc = -1;
    @(negedge clk);
    rst = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hdeadbeef; instr_err_i = 1'b1;
    @(negedge clk);
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    #1;
    check("stale_rvalid_busy", busy_o, 0);
    check("stale_rvalid_valid", out_valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base, acc0;
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = $urandom;
      merr[i] = ($urandom_range(19) == 0);
    end
    for (int i = 0; i < 4; i++) begin mem[i] = 32'h00000013; merr[i] = 1'b0; end
    mem[8'h20] = 32'h45014505;  merr[8'h20] = 1'b0;
    mem[8'h40] = 32'h00131234;  merr[8'h40] = 1'b0;
    mem[8'h41] = 32'habcd0000;  merr[8'h41] = 1'b0;
    merr[8'h48] = 1'b1;
    mem[8'h49] = 32'h00000013;  merr[8'h49] = 1'b0;
    mem[8'h80] = 32'h00100093;  merr[8'h80] = 1'b0;

    rst = 1'b1; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    instr_err_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; out_ready_i = 1'b0;
    #2;
    check("rst_req", instr_req_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", instr_addr_o, 32'h0);
    check("rst_pc", out_pc_o, 32'h0);
    check("rst_instr", out_instr_o, 32'h0);
    check("rst_flags", {out_compressed_o, out_err_o}, 0);
    @(negedge clk);
    rst = 1'b0; m_pc = 32'h0; exp_fetch = 32'h0;

    // Streaming 32-bit instructions with an eager bus.
    base = cyc;
    repeat (12) cycle(100, 100, 100, 1'b0, 32'h0);
    check("first_valid_latency", first_valid_cyc, base + 2);
    check("stream_progress", n_acc >= 4, 1);

    // Decode stalled: requests stop once buffer plus in-flight reach DEPTH.
    repeat (12) cycle(100, 100, 0, 1'b0, 32'h0);
    check("full_req_off", instr_req_o, 0);
    check("full_busy", busy_o, 1);
    check("full_no_inflight", bus_addr_q.size(), 0);

    // Two compressed instructions in one word.
    quiesce();
    cycle(0, 100, 0, 1'b1, 32'h80);
    wait_valid(100, 100, "c_first_valid");
    check("c_first_instr", out_instr_o, 32'h4505);
    check("c_first_pc", out_pc_o, 32'h80);
    check("c_first_comp", out_compressed_o, 1);
    cycle(100, 100, 100, 1'b0, 32'h0);
    check("c_second_valid", out_valid_o, 1);
    check("c_second_instr", out_instr_o, 32'h4501);
    check("c_second_pc", out_pc_o, 32'h82);

    // Unaligned target: a 32-bit instruction needs the following word.
    quiesce();
    cycle(100, 100, 0, 1'b1, 32'h102);
    repeat (3) cycle(100, 100, 0, 1'b0, 32'h0);
    check("unal_wait_second_word", out_valid_o, 0);
    cycle(100, 100, 0, 1'b0, 32'h0);
    check("unal_valid", out_valid_o, 1);
    check("unal_instr", out_instr_o, 32'h00000013);
    check("unal_pc", out_pc_o, 32'h102);
    check("unal_comp", out_compressed_o, 0);

    // Back-to-back redirects with two responses still in flight.
    quiesce();
    repeat (2) cycle(100, 0, 0, 1'b0, 32'h0);
    check("two_inflight", bus_addr_q.size(), 2);
    cycle(0, 0, 0, 1'b1, 32'h400);
    cycle(0, 0, 0, 1'b1, 32'h200);
    wait_valid(100, 100, "discard_valid");
    check("discard_pc", out_pc_o, 32'h200);
    check("discard_instr", out_instr_o, 32'h00100093);

    // Bus error on a word.
    quiesce();
    cycle(0, 100, 0, 1'b1, 32'h120);
    wait_valid(100, 100, "err_valid");
    check("err_flag", out_err_o, 1);
    check("err_comp", out_compressed_o, 0);
    check("err_pc", out_pc_o, 32'h120);
    wait_valid(100, 100, "after_err_valid");
    check("after_err_pc", out_pc_o, 32'h124);
    check("after_err_flag", out_err_o, 0);
    check("after_err_instr", out_instr_o, 32'h00000013);

    // Random traffic with occasional redirects, then a decode-starved stretch.
    acc0 = n_acc;
    for (int i = 0; i < 4000; i++) begin
      rpc = {22'h0, 9'($urandom_range(511)), 1'b0};
      cycle(70, 60, 60, ($urandom_range(99) < 3), rpc);
    end
    for (int i = 0; i < 1500; i++) begin
      rpc = {22'h0, 9'($urandom_range(511)), 1'b0};
      cycle(80, 70, 15, ($urandom_range(99) < 2), rpc);
    end
    check("random_progress", (n_acc - acc0) > 500, 1);

    // Reset in the middle of traffic, then restart from PC_RESET.
    repeat (3) cycle(100, 0, 0, 1'b0, 32'h0);
    do_reset();
    wait_valid(100, 100, "restart_valid");
    check("restart_pc", out_pc_o, 32'h0);
    check("restart_instr", out_instr_o, 32'h00000013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
